// File: rtl/ysyx_24090003_regfile_sb.sv
// Integer register file with two write ports (ALU / long-latency writeback),
// optional write-to-read bypass, hardwired x0 and a per-register pending-write scoreboard.
module ysyx_24090003_regfile_sb #(
    parameter int  XLEN    = 32,
    parameter int  NREG    = 32,
    parameter int  NRD     = 2,
    parameter bit  BYPASS  = 1'b1,
    parameter bit  ZERO_X0 = 1'b1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                 cpu_clk,
    input  logic                 cpu_rs_n,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic                 wen0,
    input  logic [AW-1:0]        waddr0,
    input  logic [XLEN-1:0]      wdata0,
    input  logic                 wen1,
    input  logic [AW-1:0]        waddr1,
    input  logic [XLEN-1:0]      wdata1,
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_rd,
    output logic                 issue_ready
);

    logic [XLEN-1:0] regs_reg [NREG];
    logic [NREG-1:0] busy_reg;
    logic [NREG-1:0] busy_next;
    logic [NREG-1:0] w0_sel;
    logic [NREG-1:0] w1_sel;
    logic            issue_accept;
    logic            issue_is_x0;

    assign issue_is_x0  = ZERO_X0 && (issue_rd == '0);
    assign issue_ready  = issue_is_x0 ? 1'b1 : !busy_reg[issue_rd];
    assign issue_accept = issue_valid && issue_ready;

    // Per-register write selects; x0 is never selected when hardwired to zero.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_wsel
        localparam bit WRITABLE = !(ZERO_X0 && (gi == 0));
        assign w0_sel[gi] = WRITABLE && wen0 && (waddr0 == AW'(gi));
        assign w1_sel[gi] = WRITABLE && wen1 && (waddr1 == AW'(gi));
    end

    always_ff @(posedge cpu_clk or negedge cpu_rs_n) begin
        if (!cpu_rs_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                // W0 has priority on an address collision
                if (w0_sel[i]) begin
                    regs_reg[i] <= wdata0;
                end else if (w1_sel[i]) begin
                    regs_reg[i] <= wdata1;
                end
            end
        end
    end

    // Writeback clears first so a same-cycle issue to the same register re-arms it.
    always_comb begin
        busy_next = busy_reg;
        if (wen1) begin
            busy_next[waddr1] = 1'b0;
        end
        if (issue_accept && !issue_is_x0) begin
            busy_next[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rs_n) begin
        if (!cpu_rs_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rport
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] port_data;
        logic            port_busy;
        logic            is_zero;
        logic            hit0;
        logic            hit1;
        logic            hit_issue;

        assign addr      = rd_addr[gi*AW +: AW];
        assign is_zero   = ZERO_X0 && (addr == '0);
        assign hit0      = BYPASS && wen0 && (waddr0 == addr);
        assign hit1      = BYPASS && wen1 && (waddr1 == addr);
        assign hit_issue = issue_accept && (issue_rd == addr);

        always_comb begin
            port_data = regs_reg[addr];
            port_busy = busy_reg[addr];
            if (is_zero) begin
                port_data = '0;
                port_busy = 1'b0;
            end else begin
                if (hit0) begin
                    port_data = wdata0;
                end else if (hit1) begin
                    port_data = wdata1;
                end
                if (hit1) begin
                    port_busy = hit_issue;
                end
            end
        end

        assign rd_data[gi*XLEN +: XLEN] = port_data;
        assign rd_busy[gi]              = port_busy;
    end

endmodule

// File: tb/tb_ysyx_24090003_regfile_sb.sv
// Directed checks on default and no-bypass register files, then a randomized
// comparison against a reference model for a 16x64, 3-read-port instance.
module tb_ysyx_24090003_regfile_sb;

    logic cpu_clk;
    logic cpu_rs_n;

    // Instances A (bypass) and B (no bypass) share stimulus.
    logic [9:0]  rd_addr_a;
    logic [63:0] rd_data_a, rd_data_b;
    logic [1:0]  rd_busy_a, rd_busy_b;
    logic        wen0, wen1, issue_valid;
    logic [4:0]  waddr0, waddr1, issue_rd;
    logic [31:0] wdata0, wdata1;
    logic        issue_ready_a, issue_ready_b;

    // Instance C: NREG=16, NRD=3, XLEN=64
    logic [11:0]  c_rd_addr;
    logic [191:0] c_rd_data;
    logic [2:0]   c_rd_busy;
    logic         c_wen0, c_wen1, c_issue_valid, c_issue_ready;
    logic [3:0]   c_waddr0, c_waddr1, c_issue_rd;
    logic [63:0]  c_wdata0, c_wdata1;

    int checks = 0;
    int errors = 0;

    ysyx_24090003_regfile_sb dut_a (
        .cpu_clk(cpu_clk), .cpu_rs_n(cpu_rs_n),
        .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready_a)
    );

    ysyx_24090003_regfile_sb #(.BYPASS(1'b0)) dut_b (
        .cpu_clk(cpu_clk), .cpu_rs_n(cpu_rs_n),
        .rd_addr(rd_addr_a), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready_b)
    );

    ysyx_24090003_regfile_sb #(.XLEN(64), .NREG(16), .NRD(3)) dut_c (
        .cpu_clk(cpu_clk), .cpu_rs_n(cpu_rs_n),
        .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_busy(c_rd_busy),
        .wen0(c_wen0), .waddr0(c_waddr0), .wdata0(c_wdata0),
        .wen1(c_wen1), .waddr1(c_waddr1), .wdata1(c_wdata1),
        .issue_valid(c_issue_valid), .issue_rd(c_issue_rd), .issue_ready(c_issue_ready)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wen0 = 0; wen1 = 0; issue_valid = 0;
        waddr0 = 0; waddr1 = 0; issue_rd = 0;
        wdata0 = 0; wdata1 = 0;
    endtask

    task automatic set_rd(input int p, input logic [4:0] a);
        rd_addr_a[p*5 +: 5] = a;
    endtask

    function automatic logic [31:0] da(input int p);
        return rd_data_a[p*32 +: 32];
    endfunction

    function automatic logic [31:0] db(input int p);
        return rd_data_b[p*32 +: 32];
    endfunction

    // Apply the currently driven inputs on the next rising edge.
    task automatic tick();
        $display("[%0t] txn w0=%0b x%0d=0x%0h w1=%0b x%0d=0x%0h issue=%0b x%0d rd=x%0d,x%0d",
                 $time, wen0, waddr0, wdata0, wen1, waddr1, wdata1,
                 issue_valid, issue_rd, rd_addr_a[4:0], rd_addr_a[9:5]);
        @(posedge cpu_clk);
        #1;
    endtask

    // Reference model for instance C
    logic [63:0] m_regs [16];
    logic [15:0] m_busy;

    initial begin
        logic [63:0] exp_d;
        logic        exp_b;
        logic [3:0]  a;
        logic        accept;

        cpu_rs_n = 0;
        idle();
        rd_addr_a = '0;
        c_rd_addr = '0;
        c_wen0 = 0; c_wen1 = 0; c_issue_valid = 0;
        c_waddr0 = 0; c_waddr1 = 0; c_issue_rd = 0;
        c_wdata0 = 0; c_wdata1 = 0;

        // Reset state
        #3;
        set_rd(0, 5); set_rd(1, 7); issue_rd = 7;
        #1;
        chk("rst_data", da(0), 32'h0);
        chk("rst_busy", rd_busy_a[1], 1'b0);
        chk("rst_ready", issue_ready_a, 1'b1);
        #3 cpu_rs_n = 1;

        // Write x5, issue x7, then asynchronous reset between edges
        idle();
        wen0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF;
        issue_valid = 1; issue_rd = 7;
        tick();
        idle(); issue_rd = 7;
        #1;
        chk("pre_rst_x5", da(0), 32'hDEADBEEF);
        chk("pre_rst_busy_x7", rd_busy_a[1], 1'b1);
        chk("pre_rst_ready_x7", issue_ready_a, 1'b0);
        #1 cpu_rs_n = 0;
        #1;
        chk("async_rst_x5", da(0), 32'h0);
        chk("async_rst_busy_x7", rd_busy_a[1], 1'b0);
        chk("async_rst_ready", issue_ready_a, 1'b1);
        #1 cpu_rs_n = 1;
        #1;
        chk("post_rst_x5", da(0), 32'h0);

        // Dual write to different addresses, then same-address conflict
        idle();
        wen0 = 1; waddr0 = 3; wdata0 = 32'h11;
        wen1 = 1; waddr1 = 4; wdata1 = 32'h22;
        tick();
        idle(); set_rd(0, 3); set_rd(1, 4);
        #1;
        chk("dual_x3", da(0), 32'h11);
        chk("dual_x4", da(1), 32'h22);
        wen0 = 1; waddr0 = 9; wdata0 = 32'hAA;
        wen1 = 1; waddr1 = 9; wdata1 = 32'hBB;
        tick();
        idle(); set_rd(0, 9);
        #1;
        chk("conflict_x9", da(0), 32'hAA);

        // Bypass vs. no bypass
        wen0 = 1; waddr0 = 6; wdata0 = 32'h777;
        tick();
        idle(); set_rd(0, 6);
        wen1 = 1; waddr1 = 6; wdata1 = 32'h1234;
        #1;
        chk("bypass_on_x6", da(0), 32'h1234);
        chk("bypass_off_x6_old", db(0), 32'h777);
        tick();
        idle();
        #1;
        chk("bypass_off_x6_new", db(0), 32'h1234);
        chk("bypass_on_x6_stored", da(0), 32'h1234);
        wen0 = 1; waddr0 = 6; wdata0 = 32'h5;
        wen1 = 1; waddr1 = 6; wdata1 = 32'h6;
        #1;
        chk("bypass_both_w0_wins", da(0), 32'h5);
        tick();
        idle();

        // x0 hardwired
        wen0 = 1; waddr0 = 0; wdata0 = 32'hFFFFFFFF;
        issue_valid = 1; issue_rd = 0;
        set_rd(0, 0); set_rd(1, 0);
        #1;
        chk("x0_bypass_data", da(0), 32'h0);
        chk("x0_busy", rd_busy_a[0], 1'b0);
        chk("x0_ready", issue_ready_a, 1'b1);
        tick();
        #1;
        chk("x0_after_data", da(1), 32'h0);
        chk("x0_after_busy", rd_busy_a[1], 1'b0);
        chk("x0_after_ready", issue_ready_a, 1'b1);
        idle();

        // Scoreboard: issue x8, WAW stall for 3 cycles, then writeback
        issue_valid = 1; issue_rd = 8; set_rd(1, 8);
        #1;
        chk("sb_ready_before", issue_ready_a, 1'b1);
        tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("sb_busy_x8", rd_busy_a[1], 1'b1);
            chk("sb_stall_x8", issue_ready_a, 1'b0);
            tick();
        end
        idle(); set_rd(1, 8);
        wen1 = 1; waddr1 = 8; wdata1 = 32'h55;
        #1;
        chk("sb_wb_bypass_busy", rd_busy_a[1], 1'b0);
        chk("sb_wb_bypass_data", da(1), 32'h55);
        chk("sb_wb_nobypass_busy", rd_busy_b[1], 1'b1);
        tick();
        idle(); issue_rd = 8;
        #1;
        chk("sb_cleared_busy", rd_busy_a[1], 1'b0);
        chk("sb_cleared_ready", issue_ready_a, 1'b1);
        chk("sb_cleared_data", da(1), 32'h55);
        issue_valid = 1; issue_rd = 8;
        wen1 = 1; waddr1 = 8; wdata1 = 32'h66;
        tick();
        idle(); issue_rd = 8;
        #1;
        chk("sb_set_wins_busy", rd_busy_a[1], 1'b1);
        chk("sb_set_wins_ready", issue_ready_a, 1'b0);
        chk("sb_set_wins_data", da(1), 32'h66);
        wen1 = 1; waddr1 = 8; wdata1 = 32'h0;
        tick();
        idle();

        // Randomized sweep of instance C against the reference model
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_busy = '0;
        for (int c = 0; c < 10000; c++) begin
            @(posedge cpu_clk);
            #1;
            c_wen0 = ($urandom_range(0, 2) == 0);
            c_waddr0 = 4'($urandom_range(0, 15));
            c_wdata0 = {$urandom, $urandom};
            c_wen1 = ($urandom_range(0, 2) == 0);
            c_waddr1 = ($urandom_range(0, 1) == 0) ? c_waddr0 : 4'($urandom_range(0, 15));
            c_wdata1 = {$urandom, $urandom};
            c_issue_valid = ($urandom_range(0, 1) == 0);
            c_issue_rd = 4'($urandom_range(0, 15));
            c_rd_addr = 12'($urandom);
            #2;
            accept = c_issue_valid && ((c_issue_rd == 0) || !m_busy[c_issue_rd]);
            chk("sweep_ready", c_issue_ready, (c_issue_rd == 0) || !m_busy[c_issue_rd]);
            for (int p = 0; p < 3; p++) begin
                a = c_rd_addr[p*4 +: 4];
                exp_d = m_regs[a];
                exp_b = m_busy[a];
                if (c_wen0 && c_waddr0 == a) exp_d = c_wdata0;
                else if (c_wen1 && c_waddr1 == a) exp_d = c_wdata1;
                if (c_wen1 && c_waddr1 == a) exp_b = accept && (c_issue_rd == a);
                if (a == 0) begin
                    exp_d = '0;
                    exp_b = 1'b0;
                end
                chk("sweep_data", c_rd_data[p*64 +: 64], exp_d);
                chk("sweep_busy", c_rd_busy[p], exp_b);
            end
            // State after the coming edge
            if (c_wen1 && c_waddr1 != 0 && !(c_wen0 && c_waddr0 == c_waddr1))
                m_regs[c_waddr1] = c_wdata1;
            if (c_wen0 && c_waddr0 != 0)
                m_regs[c_waddr0] = c_wdata0;
            if (c_wen1) m_busy[c_waddr1] = 1'b0;
            if (accept && c_issue_rd != 0) m_busy[c_issue_rd] = 1'b1;
            if (c % 1000 == 999)
                $display("[%0t] sweep cycles %0d..%0d done, errors so far %0d", $time, c - 999, c, errors);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
